image_reveal_ctrl: RTL and testbench

//  Frame-synchronous controller for the image ROM drawer. Accepts a show request

---
 rtl/image_reveal_ctrl_pkg.sv | 15 +
 rtl/image_reveal_ctrl_frame_tick_gen.sv | 19 +
 rtl/image_reveal_ctrl.sv | 146 ++++++++++++++
 tb/tb_image_reveal_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/image_reveal_ctrl_pkg.sv
// Shared definitions for the image reveal controller: state encodings and default sizing.
package image_reveal_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_SHOWING  = 2'd2,
      ST_CLEARING = 2'd3
   } state_e;

   localparam int DEF_IMG_W        = 3;
   localparam int DEF_HOLD_FRAMES  = 60;
   localparam int DEF_BLINK_FRAMES = 30;

endpackage

// File: rtl/image_reveal_ctrl_frame_tick_gen.sv
// Frame tick generator: one-cycle pulse on each rising edge of vblnk.
module frame_tick_gen (
   input  logic pclk,
   input  logic rst_n,
   input  logic vblnk,
   output logic tick
);

   logic vblnk_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) vblnk_q <= 1'b0;
      else        vblnk_q <= vblnk;
   end

   assign tick = vblnk & ~vblnk_q;

endmodule

// File: rtl/image_reveal_ctrl.sv
// Frame-synchronous show/hide controller for the image ROM drawer.
// Optional blinking tail of the hold period is enabled by defining IMAGE_REVEAL_BLINK_EN.
module image_reveal_ctrl
   import image_reveal_ctrl_pkg::*;
#(
   parameter int IMG_W        = DEF_IMG_W,
   parameter int HOLD_FRAMES  = DEF_HOLD_FRAMES,
   parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             vblnk,
   input  logic             show_req,
   input  logic [IMG_W-1:0] show_img,
   input  logic             hide_req,
   output logic             show_ack,
   output logic             enable,
   output logic [IMG_W-1:0] img_sel,
   output logic             busy,
   output logic             done
);

   localparam int            CW          = $clog2(HOLD_FRAMES + 1);
   localparam logic [CW-1:0] LAST_CNT    = CW'(HOLD_FRAMES - 1);
   localparam logic [CW-1:0] BLINK_START = CW'(HOLD_FRAMES - BLINK_FRAMES);
`ifdef IMAGE_REVEAL_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_int_n = rst_sync_q[1];

   logic tick;

   frame_tick_gen u_tick (
      .pclk  (pclk),
      .rst_n (rst_int_n),
      .vblnk (vblnk),
      .tick  (tick)
   );

   state_e           state_q,   state_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic             enable_q,  enable_d;
   logic [IMG_W-1:0] img_sel_q, img_sel_d;
   logic             ack_q,     ack_d;
   logic             done_q,    done_d;
   logic             busy_q,    busy_d;
   logic [CW-1:0]    cnt_inc;

   assign cnt_inc = cnt_q + CW'(1);

   always_ff @(posedge pclk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         enable_q  <= 1'b0;
         img_sel_q <= '0;
         ack_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         enable_q  <= enable_d;
         img_sel_q <= img_sel_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      enable_d  = enable_q;
      img_sel_d = img_sel_q;
      ack_d     = 1'b0;
      done_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            enable_d = 1'b0;
            if (show_req && !hide_req) begin
               img_sel_d = show_img;
               ack_d     = 1'b1;
               state_d   = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (hide_req) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               state_d  = ST_SHOWING;
               enable_d = 1'b1;
               cnt_d    = '0;
            end
         end
         ST_SHOWING: begin
            if (hide_req) begin
               state_d = ST_CLEARING;
            end else if (tick) begin
               if (cnt_q == LAST_CNT) begin
                  state_d  = ST_IDLE;
                  enable_d = 1'b0;
                  done_d   = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
                  // Blinking frames alternate, starting dark at the first blink frame.
                  if (BLINK_ON && (cnt_inc >= BLINK_START)) enable_d = ~enable_q;
               end
            end
         end
         ST_CLEARING: begin
            if (tick) begin
               state_d  = ST_IDLE;
               enable_d = 1'b0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            enable_d = 1'b0;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign show_ack = ack_q;
   assign enable   = enable_q;
   assign img_sel  = img_sel_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_image_reveal_ctrl.sv
// Self-checking bench for image_reveal_ctrl: directed scenarios plus random traffic vs a frame-level model.
module tb_image_reveal_ctrl;

   localparam int IW = 3;
`ifdef IMAGE_REVEAL_BLINK_EN
   localparam int HOLD  = 6;
   localparam int BLINK = 2;
   localparam bit BL    = 1'b1;
`else
   localparam int HOLD  = 3;
   localparam int BLINK = 2;
   localparam bit BL    = 1'b0;
`endif

   logic          pclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          vblnk = 1'b0;
   logic          show_req = 1'b0;
   logic [IW-1:0] show_img = '0;
   logic          hide_req = 1'b0;
   logic          show_ack, enable, busy, done;
   logic [IW-1:0] img_sel;

   image_reveal_ctrl #(
      .IMG_W        (IW),
      .HOLD_FRAMES  (HOLD),
      .BLINK_FRAMES (BLINK)
   ) dut (
      .pclk     (pclk),
      .rst_n    (rst_n),
      .vblnk    (vblnk),
      .show_req (show_req),
      .show_img (show_img),
      .hide_req (hide_req),
      .show_ack (show_ack),
      .enable   (enable),
      .img_sel  (img_sel),
      .busy     (busy),
      .done     (done)
   );

   always #5 pclk = ~pclk;

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;
   int n_en = 0;

   // Reference model: frames still to show, pending arm, and a clearing flag.
   bit            m_pending, m_clearing, m_en_hold, m_ack, m_done, m_prev_vb;
   int            m_left;
   logic [IW-1:0] m_img;

   function automatic bit exp_enable();
      int fi;
      if (m_left > 0) begin
         fi = HOLD - m_left;
         if (BL && fi >= HOLD - BLINK) return ((fi - (HOLD - BLINK)) % 2) != 0;
         return 1'b1;
      end
      return m_clearing ? m_en_hold : 1'b0;
   endfunction

   function automatic bit exp_busy();
      return m_pending || (m_left > 0) || m_clearing;
   endfunction

   task automatic model_reset();
      m_pending = 0; m_clearing = 0; m_en_hold = 0; m_ack = 0; m_done = 0;
      m_prev_vb = 0; m_left = 0; m_img = '0;
   endtask

   task automatic model_step();
      bit tick;
      tick   = vblnk && !m_prev_vb;
      m_ack  = 0;
      m_done = 0;
      if (!exp_busy()) begin
         if (show_req && !hide_req) begin
            m_pending = 1; m_img = show_img; m_ack = 1;
         end
      end else if (m_pending) begin
         if (hide_req) m_pending = 0;
         else if (tick) begin
            m_pending = 0; m_left = HOLD;
         end
      end else if (m_left > 0) begin
         if (hide_req) begin
            m_en_hold = exp_enable(); m_clearing = 1; m_left = 0;
         end else if (tick) begin
            m_left--;
            if (m_left == 0) m_done = 1;
         end
      end else if (m_clearing) begin
         if (tick) m_clearing = 0;
      end
      m_prev_vb = vblnk;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".enable"},  int'(enable),   int'(exp_enable()));
      check({tag, ".busy"},    int'(busy),     int'(exp_busy()));
      check({tag, ".ack"},     int'(show_ack), int'(m_ack));
      check({tag, ".done"},    int'(done),     int'(m_done));
      check({tag, ".img_sel"}, int'(img_sel),  int'(m_img));
   endtask

   task automatic cycle(input bit s, input logic [IW-1:0] img, input bit h, input bit vb,
                        input string tag);
      show_req = s; show_img = img; hide_req = h; vblnk = vb;
      @(posedge pclk);
      model_step();
      @(negedge pclk);
      if (done === 1'b1) n_done++;
      if (enable === 1'b1) n_en++;
      check_all(tag);
   endtask

   // One frame: vblnk high for two cycles, low for four; the tick lands on the first cycle.
   task automatic frames(input int n, input string tag);
      for (int f = 0; f < n; f++) begin
         cycle(0, '0, 0, 1, tag);
         cycle(0, '0, 0, 1, tag);
         for (int k = 0; k < 4; k++) cycle(0, '0, 0, 0, tag);
      end
   endtask

   initial begin
      int pat[$];
      int done0, en0, pos, flen;
      bit vb;

      model_reset();
      @(negedge pclk);
      check_all("reset");
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) cycle(0, '0, 0, 0, "post_reset");

      // Normal display of image 5, recording enable on each tick cycle.
      done0 = n_done; en0 = n_en;
      cycle(1, 3'd5, 0, 0, "normal_req");
      check("normal.ack", int'(show_ack), 1);
      check("normal.img", int'(img_sel), 5);
      for (int f = 0; f <= HOLD; f++) begin
         cycle(0, '0, 0, 1, "normal");
         pat.push_back(int'(enable));
         cycle(0, '0, 0, 1, "normal");
         for (int k = 0; k < 4; k++) cycle(0, '0, 0, 0, "normal");
      end
      if (BL) begin
         check("blink.len", pat.size(), 7);
         check("blink.f0", pat[0], 1); check("blink.f3", pat[3], 1);
         check("blink.f4", pat[4], 0); check("blink.f5", pat[5], 1);
         check("blink.end", pat[6], 0);
      end else begin
         check("normal.f0", pat[0], 1); check("normal.f2", pat[2], 1);
         check("normal.end", pat[3], 0);
         check("normal.en_cycles", n_en - en0, HOLD * 6);
      end
      check("normal.done_count", n_done - done0, 1);

      // Retrigger while showing: ignored.
      cycle(1, 3'd5, 0, 0, "retrig_req");
      frames(1, "retrig_arm");
      cycle(1, 3'd2, 0, 0, "retrig_ignored");
      check("retrig.ack", int'(show_ack), 0);
      check("retrig.img", int'(img_sel), 5);
      frames(HOLD + 1, "retrig_drain");

      // Hide while armed: enable never rises, no done.
      done0 = n_done; en0 = n_en;
      cycle(1, 3'd1, 0, 0, "hide_arm_req");
      cycle(0, '0, 1, 0, "hide_arm");
      frames(2, "hide_arm_after");
      check("hide_arm.en_cycles", n_en - en0, 0);
      check("hide_arm.done", n_done - done0, 0);

      // Hide while showing: enable held until next tick, no done.
      done0 = n_done;
      cycle(1, 3'd3, 0, 0, "hide_show_req");
      frames(1, "hide_show_arm");
      cycle(0, '0, 1, 0, "hide_show");
      check("hide_show.held", int'(enable), 1);
      frames(2, "hide_show_after");
      check("hide_show.done", n_done - done0, 0);

      // Simultaneous show and hide in IDLE.
      cycle(1, 3'd6, 1, 0, "simul");
      check("simul.ack", int'(show_ack), 0);
      check("simul.busy", int'(busy), 0);

      // Request on a tick cycle: that tick does not count.
      cycle(1, 3'd4, 0, 1, "tick_req");
      cycle(0, '0, 0, 1, "tick_req");
      for (int k = 0; k < 4; k++) cycle(0, '0, 0, 0, "tick_req");
      check("tick_req.not_yet", int'(enable), 0);
      frames(HOLD + 1, "tick_req_drain");

      // Asynchronous reset mid-display.
      cycle(1, 3'd7, 0, 0, "areset_req");
      frames(1, "areset_show");
      cycle(0, '0, 0, 0, "areset_mid");
      #2 rst_n = 1'b0;
      #1;
      check("areset.enable", int'(enable), 0);
      check("areset.img", int'(img_sel), 0);
      check("areset.busy", int'(busy), 0);
      check("areset.ack", int'(show_ack), 0);
      check("areset.done", int'(done), 0);
      model_reset();
      @(negedge pclk);
      @(negedge pclk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) cycle(0, '0, 0, 0, "areset_release");

      // Random traffic with irregular frame lengths.
      pos = 0; flen = 6;
      for (int c = 0; c < 4000; c++) begin
         vb = (pos < 2);
         cycle(($urandom_range(0, 99) < 30), IW'($urandom_range(0, 7)),
               ($urandom_range(0, 99) < 4), vb, "random");
         pos++;
         if (pos >= flen) begin
            pos = 0;
            flen = $urandom_range(4, 9);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
